ifu: RTL and testbench

//  Instruction fetch unit for the single-cycle MIPS core: holds the PC, reads the instruction ROM
//  and computes the next PC. Next-PC selection comes from the controller's NPCOp and Br outputs.

---
 rtl/ifu_pkg.sv | 19 +
 rtl/ifu_npc.sv | 27 ++
 rtl/ifu.sv | 53 +++++
 tb/tb_ifu.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC encodings, reset PC and ROM size.
// The controller reuses npc_op_e so both sides agree on the NPCOp encoding.
package ifu_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam int          IM_DEPTH_DEFAULT = 1024;

  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC computation: sequential, conditional branch, J-type jump, register jump.
// All arithmetic wraps modulo 2^32; a jr target is passed through untouched, even if misaligned.
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [31:0] PC,
  input  logic [25:0] instr_idx,
  input  npc_op_e     NPCOp,
  input  logic        Br,
  input  logic [31:0] RA,
  output logic [31:0] NPC,
  output logic [31:0] PC4
);

  always_comb begin
    PC4 = PC + 32'd4;
    NPC = PC4;
    case (NPCOp)
      NPC_SEQ: NPC = PC4;
      NPC_BR:  NPC = Br ? (PC4 + br_offset(instr_idx[15:0])) : PC4;
      NPC_J:   NPC = {PC4[31:28], instr_idx, 2'b00};
      NPC_JR:  NPC = RA;
      default: NPC = PC4;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, instruction ROM, range/alignment check and en/reset muxing.
// The ROM image is supplied as a packed parameter, word i at bits [32*i +: 32].
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0]           PC_RESET = PC_RESET_DEFAULT,
  parameter int                    IM_DEPTH = IM_DEPTH_DEFAULT,
  parameter logic [32*IM_DEPTH-1:0] IM_INIT = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  NPCOp,
  input  logic        Br,
  input  logic [31:0] RA,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        fetch_err
);

  localparam int          AW       = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
  localparam logic [31:0] IM_BYTES = 32'(4 * IM_DEPTH);

  logic [31:0]   offset;
  logic [31:0]   npc;
  logic [AW-1:0] idx;

  // Addresses below PC_RESET wrap to a huge offset and fail the same bound check.
  assign offset    = PC - PC_RESET;
  assign idx       = offset[AW+1:2];
  assign fetch_err = (PC[1:0] != 2'b00) || (offset >= IM_BYTES);
  assign Instr     = fetch_err ? 32'h0000_0000 : IM_INIT[32*idx +: 32];

  ifu_npc u_npc (
    .PC        (PC),
    .instr_idx (Instr[25:0]),
    .NPCOp     (npc_op_e'(NPCOp)),
    .Br        (Br),
    .RA        (RA),
    .NPC       (npc),
    .PC4       (PC4)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= PC_RESET;
    end else if (en) begin
      PC <= npc;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: each step predicts the post-edge PC/Instr/PC4/fetch_err from a
// reference model, queues it, and compares after the edge.
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          DEPTH  = 1024;

  function automatic logic [31:0] img_word(input int i);
    logic [15:0] lo;
    lo = 16'(i);
    case (i)
      4:       return 32'h1000_FFFC;   // beq, imm16 = -4
      8:       return 32'h0C00_0C10;   // jal 26'h0000C10
      12:      return 32'h1000_FFFF;   // beq to self
      1023:    return 32'hDEAD_BEEF;
      default: return {16'hA5A5, lo};
    endcase
  endfunction

  function automatic logic [32*DEPTH-1:0] mk_img();
    logic [32*DEPTH-1:0] img;
    img = '0;
    for (int i = 0; i < DEPTH; i++) img[32*i +: 32] = img_word(i);
    return img;
  endfunction

  localparam logic [32*DEPTH-1:0] IMG = mk_img();

  logic        clk = 1'b0;
  logic        reset, en, Br;
  logic [1:0]  NPCOp;
  logic [31:0] RA;
  logic [31:0] Instr, PC, PC4;
  logic        fetch_err;

  ifu #(.PC_RESET(RST_PC), .IM_DEPTH(DEPTH), .IM_INIT(IMG)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .NPCOp     (NPCOp),
    .Br        (Br),
    .RA        (RA),
    .Instr     (Instr),
    .PC        (PC),
    .PC4       (PC4),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mpc;

  function automatic logic m_err(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < RST_PC) || (pc >= RST_PC + 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] m_instr(input logic [31:0] pc);
    if (m_err(pc)) return 32'h0;
    return img_word(int'((pc - RST_PC) / 4));
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc, input logic [1:0] op,
                                         input logic br, input logic [31:0] ra);
    logic [31:0] ins, seq, off;
    ins = m_instr(pc);
    seq = pc + 32'd4;
    off = 32'($signed(ins[15:0])) * 32'd4;
    case (op)
      2'b00:   return seq;
      2'b01:   return br ? seq + off : seq;
      2'b10:   return {seq[31:28], ins[25:0], 2'b00};
      default: return ra;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, want, $time);
      end
  endtask

  // Drive one cycle, predict the post-edge state, then compare against the DUT.
  task automatic step(input logic r, input logic e, input logic [1:0] op, input logic br,
                      input logic [31:0] ra);
    exp_t x, y;
    reset = r; en = e; NPCOp = op; Br = br; RA = ra;
    if (r)      mpc = RST_PC;
    else if (e) mpc = m_next(mpc, op, br, ra);
    x.pc = mpc; x.instr = m_instr(mpc); x.pc4 = mpc + 32'd4; x.err = m_err(mpc);
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL scoreboard: observed empty expected entry");
    end else begin
      y = sb.pop_front();
      check("pc",    PC,              y.pc);
      check("instr", Instr,           y.instr);
      check("pc4",   PC4,             y.pc4);
      check("err",   32'(fetch_err),  32'(y.err));
    end
  endtask

  task automatic seq_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 2'b00, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; NPCOp = 2'b00; Br = 1'b0; RA = '0;
    mpc = RST_PC;
    @(posedge clk); #1;

    // 1: reset, then sequential fetch
    step(1'b1, 1'b1, 2'b10, 1'b1, 32'h1234);
    check("rst_pc",    PC,    32'h0000_3000);
    check("rst_instr", Instr, img_word(0));
    seq_n(3);
    check("seq_pc3", PC, 32'h0000_300C);

    // 2: beq taken / not taken at 0x3010
    seq_n(1);
    step(1'b0, 1'b1, 2'b01, 1'b1, 32'h0);
    check("beq_taken", PC, 32'h0000_3004);
    seq_n(3);
    check("beq_at", PC, 32'h0000_3010);
    step(1'b0, 1'b1, 2'b01, 1'b0, 32'h0);
    check("beq_not_taken", PC, 32'h0000_3014);

    // 3: jal at 0x3020
    seq_n(3);
    check("jal_pc4_link", PC4, 32'h0000_3024);
    step(1'b0, 1'b1, 2'b10, 1'b0, 32'h0);
    check("jal_target", PC, 32'h0000_3040);

    // 4: jr to a misaligned address, then back to a legal one
    step(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_3102);
    check("jr_mis_err", 32'(fetch_err), 32'd1);
    check("jr_mis_ins", Instr, 32'h0);
    step(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_3008);
    check("jr_ok_ins", Instr, img_word(2));

    // 5: hold with en=0, then reset overriding en=0
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b01, 1'b1, 32'hFFFF_0000);
    check("hold_pc", PC, 32'h0000_3008);
    step(1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_3100);
    check("rst_en0", PC, 32'h0000_3000);

    // 6: walk to the top of the IM and past it, then below it
    seq_n(1023);
    check("last_word", Instr, 32'hDEAD_BEEF);
    seq_n(1);
    check("end_pc",  PC, 32'h0000_4000);
    check("end_err", 32'(fetch_err), 32'd1);
    step(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_2FFC);
    check("below_err", 32'(fetch_err), 32'd1);

    // Wrap-around and branch-to-self
    step(1'b0, 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFC);
    seq_n(1);
    check("wrap_pc", PC, 32'h0000_0000);
    step(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_3030);
    step(1'b0, 1'b1, 2'b01, 1'b1, 32'h0);
    step(1'b0, 1'b1, 2'b01, 1'b1, 32'h0);
    check("self_br", PC, 32'h0000_3030);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
